fp32_recip_w: RTL and testbench

// - Perspective-divide front end: takes a clip-space vertex {x,y,z,w} (fp32), computes 1/w, presents
//   the vertex plus 1/w as (a_in, b_in) to the downstream fp32_scale stage.
// - Iterative: one shared fixed-point multiplier, LUT seed + Newton-Raphson; one vertex in flight at a time.

---
 rtl/fp32_pkg.sv | 29 ++
 rtl/fp32_recip_seed.sv | 22 ++
 rtl/fp32_recip_w.sv | 153 +++++++++++++++
 tb/tb_fp32_recip_w.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 field layout, constants and state/class encodings for the
// reciprocal front end.
package fp32_pkg;

  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_BIAS   = 127;

  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {IDLE, SEED, MUL_A, MUL_B, PACK} recip_state_t;

  typedef enum logic [1:0] {W_NORMAL, W_ZERO, W_INF, W_NAN} w_class_t;

  // Denormals are treated as zero.
  function automatic w_class_t classify(input fp32_t w);
    if (w.exp == '1) return (w.mant == '0) ? W_INF : W_NAN;
    if (w.exp == '0) return W_ZERO;
    return W_NORMAL;
  endfunction

endpackage

// File: rtl/fp32_recip_seed.sv
// Seed ROM: approximate 1/1.m from the top SEED_BITS mantissa bits,
// unsigned with SEED_BITS+2 fractional bits.
module fp32_recip_seed #(
  parameter int unsigned SEED_BITS = 6
) (
  input  logic [SEED_BITS-1:0] idx_in,
  output logic [SEED_BITS+1:0] seed_out
);

  logic [SEED_BITS+1:0] rom [2**SEED_BITS];

  // Entry = round(2^(2S+3) / (2^(S+1) + 2i + 1)), the reciprocal of the bin midpoint.
  for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_rom
    localparam int unsigned NUM = 2**(2*SEED_BITS+3);
    localparam int unsigned DEN = 2**(SEED_BITS+1) + 2*i + 1;
    localparam int unsigned VAL = (2*NUM + DEN) / (2*DEN);
    assign rom[i] = VAL[SEED_BITS+1:0];
  end

  assign seed_out = rom[idx_in];

endmodule

// File: rtl/fp32_recip_w.sv
// Perspective-divide front end: iterative fp32 1/w (LUT seed + Newton-Raphson
// on one shared multiplier), presented alongside the unchanged vertex.
module fp32_recip_w
  import fp32_pkg::*;
#(
  parameter int unsigned ITERS     = 2,
  parameter int unsigned SEED_BITS = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0][31:0] v_in,
  output logic             valid_out,
  output logic [3:0][31:0] v_out,
  output logic [31:0]      recip_out
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam logic [31:0] TWO_Q = 32'h8000_0000;

  recip_state_t     state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [3:0][31:0] v_q, v_d;
  w_class_t         cls_q, cls_d;
  logic [31:0]      x_q, x_d, t_q, t_d;
  logic [3:0][31:0] v_out_q, v_out_d;
  logic [31:0]      recip_q, recip_d;
  logic             valid_q, valid_d;

  fp32_t                w_f;
  logic [31:0]          m_fix, x0;
  logic [SEED_BITS+1:0] seed;
  logic [31:0]          mul_a, mul_b, mul_res;
  logic [63:0]          prod;
  logic                 mant_zero, flush;
  logic [7:0]           exp_res;
  logic [22:0]          mant_res;
  logic [31:0]          pack_res;

  assign w_f   = v_q[3];
  assign m_fix = {2'b01, w_f.mant, 7'b0};

  fp32_recip_seed #(.SEED_BITS(SEED_BITS)) u_seed (
    .idx_in   (w_f.mant[22 -: SEED_BITS]),
    .seed_out (seed)
  );

  assign x0      = 32'(seed) << (30 - SEED_BITS - 2);
  assign prod    = 64'(mul_a) * 64'(mul_b);
  assign mul_res = 32'(prod >> 30);

  always_comb begin
    mul_a = m_fix;
    mul_b = x_q;
    unique case (state_q)
      SEED:    mul_b = x0;
      MUL_B: begin
        mul_a = x_q;
        mul_b = TWO_Q - t_q;
      end
      default: ;
    endcase
  end

  assign mant_zero = (w_f.mant == '0);
  assign exp_res   = mant_zero ? 8'd254 - w_f.exp : 8'd253 - w_f.exp;
  assign flush     = mant_zero ? (w_f.exp >= 8'd254) : (w_f.exp >= 8'd253);
  assign mant_res  = mant_zero ? '0 : x_q[28:6];

  always_comb begin
    pack_res = {w_f.sign, exp_res, mant_res};
    unique case (cls_q)
      W_NAN:   pack_res = FP32_QNAN;
      W_INF:   pack_res = {w_f.sign, 31'b0};
      W_ZERO:  pack_res = FP32_POS_INF | {w_f.sign, 31'b0};
      default: if (flush) pack_res = {w_f.sign, 31'b0};
    endcase
  end

  // The first t = m*x0 is formed in SEED alongside the seed load, so each
  // iteration after it costs MUL_B (+ MUL_A) and the total stays 2*ITERS+2.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    v_d     = v_q;
    cls_d   = cls_q;
    x_d     = x_q;
    t_d     = t_q;
    v_out_d = v_out_q;
    recip_d = recip_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (valid_in) begin
        v_d     = v_in;
        cls_d   = classify(fp32_t'(v_in[3]));
        state_d = SEED;
      end
      SEED: begin
        x_d     = x0;
        t_d     = mul_res;
        iter_d  = '0;
        state_d = MUL_B;
      end
      MUL_A: begin
        t_d     = mul_res;
        state_d = MUL_B;
      end
      MUL_B: begin
        x_d     = mul_res;
        iter_d  = iter_q + CNT_W'(1);
        state_d = (iter_q == CNT_W'(ITERS - 1)) ? PACK : MUL_A;
      end
      PACK: begin
        recip_d = pack_res;
        v_out_d = v_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      iter_q  <= '0;
      v_q     <= '0;
      cls_q   <= W_NORMAL;
      x_q     <= '0;
      t_q     <= '0;
      v_out_q <= '0;
      recip_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      v_q     <= v_d;
      cls_q   <= cls_d;
      x_q     <= x_d;
      t_q     <= t_d;
      v_out_q <= v_out_d;
      recip_q <= recip_d;
      valid_q <= valid_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = valid_q;
  assign v_out     = v_out_q;
  assign recip_out = recip_q;

endmodule

// File: tb/tb_fp32_recip_w.sv
// Bench for fp32_recip_w: directed table, random normals against a real-arithmetic
// reference, back-to-back throughput and mid-operation reset.
`timescale 1ns/1ps
module tb_fp32_recip_w;

  localparam int unsigned ITERS     = 2;
  localparam int unsigned SEED_BITS = 6;
  localparam int unsigned LAT       = 2*ITERS + 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             valid_in;
  logic             ready_out;
  logic [3:0][31:0] v_in;
  logic             valid_out;
  logic [3:0][31:0] v_out;
  logic [31:0]      recip_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  fp32_recip_w #(.ITERS(ITERS), .SEED_BITS(SEED_BITS)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .v_in      (v_in),
    .valid_out (valid_out),
    .v_out     (v_out),
    .recip_out (recip_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] req,
                            input int unsigned tol);
    logic [31:0] d;
    d = (act > req) ? act - req : req - act;
    total++;
    if (act[31] !== req[31] || d > tol) begin
      bad++;
      $display("FAIL %s: act=%h req=%h tol=%0d", name, act, req, tol);
    end
  endtask

  function automatic real fp_to_real(input logic [31:0] f);
    logic [10:0] e64;
    e64 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e64, f[22:0], 29'b0});
  endfunction

  // Reference: special-value rules, then exact 1/w rounded to nearest fp32.
  function automatic logic [31:0] ref_recip(input logic [31:0] w);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] rb;
    logic [23:0] m;
    int          e32;
    s = w[31]; e = w[30:23]; f = w[22:0];
    if (e == 8'hFF) return (f != 0) ? 32'h7FC0_0000 : {s, 31'b0};
    if (e == 8'h00) return {s, 8'hFF, 23'b0};
    if (e >= 8'd254 || (e == 8'd253 && f != 0)) return {s, 31'b0};
    rb  = $realtobits(1.0 / fp_to_real({1'b0, w[30:0]}));
    e32 = int'(rb[62:52]) - 896;
    m   = {1'b0, rb[51:29]} + 24'(rb[28]);
    if (m[23]) begin
      e32++;
      m = '0;
    end
    return {s, e32[7:0], m[22:0]};
  endfunction

  function automatic logic [3:0][31:0] mk_vertex(input logic [31:0] w);
    logic [3:0][31:0] v;
    v[0] = $urandom; v[1] = $urandom; v[2] = $urandom; v[3] = w;
    return v;
  endfunction

  task automatic run_vertex(input logic [3:0][31:0] v, input logic [31:0] req,
                            input int unsigned tol, input string tag);
    int unsigned lat;
    bit          busy_ok;
    valid_in = 1'b1;
    v_in     = v;
    for (int unsigned i = 0; i < 50 && !ready_out; i++) step();
    if (!ready_out) begin
      check_eq({tag, "_ready_timeout"}, 128'(ready_out), 128'(1));
      valid_in = 1'b0;
      return;
    end
    step();
    valid_in = 1'b0;
    v_in     = {$urandom, $urandom, $urandom, $urandom};
    lat      = 1;
    busy_ok  = 1'b1;
    while (!valid_out && lat < 4*LAT) begin
      if (ready_out) busy_ok = 1'b0;
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'(LAT));
    check_eq({tag, "_busy"}, 128'(busy_ok), 128'(1));
    check_eq({tag, "_ready_at_valid"}, 128'(ready_out), 128'(1));
    check_near({tag, "_recip"}, recip_out, req, tol);
    check_eq({tag, "_vout"}, v_out, v);
    step();
    check_eq({tag, "_pulse"}, 128'(valid_out), 128'(0));
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] req;
    int unsigned tol;
  } vec_t;

  initial begin
    vec_t             tbl[$];
    logic [3:0][31:0] bv[3];
    logic [3:0][31:0] rv;
    int unsigned      acc[$];
    int unsigned      outc[$];
    logic [31:0]      outr[$];
    int unsigned      rdy_cnt;
    bit               stale;
    logic [31:0]      w;

    tbl.push_back('{32'h3F80_0000, 32'h3F80_0000, 0});
    tbl.push_back('{32'h4000_0000, 32'h3F00_0000, 0});
    tbl.push_back('{32'hC080_0000, 32'hBE80_0000, 0});
    tbl.push_back('{32'h4040_0000, 32'h3EAA_AAAB, 1});
    tbl.push_back('{32'h3FFF_FFFF, ref_recip(32'h3FFF_FFFF), 1});
    tbl.push_back('{32'h0000_0000, 32'h7F80_0000, 0});
    tbl.push_back('{32'h8000_0000, 32'hFF80_0000, 0});
    tbl.push_back('{32'h7F80_0000, 32'h0000_0000, 0});
    tbl.push_back('{32'hFF80_0000, 32'h8000_0000, 0});
    tbl.push_back('{32'h7FC0_0001, 32'h7FC0_0000, 0});
    tbl.push_back('{32'h7E80_0000, 32'h0080_0000, 0});
    tbl.push_back('{32'h7F00_0000, 32'h0000_0000, 0});
    tbl.push_back('{32'h0000_0001, 32'h7F80_0000, 0});
    tbl.push_back('{32'hBEFF_FFFF, ref_recip(32'hBEFF_FFFF), 1});

    rst_in   = 1'b0;
    valid_in = 1'b0;
    v_in     = '0;
    step(); step();
    check_eq("rst_ready", 128'(ready_out), 128'(1));
    check_eq("rst_valid", 128'(valid_out), 128'(0));
    check_eq("rst_vout", v_out, '0);
    check_eq("rst_recip", 128'(recip_out), 128'(0));
    rst_in = 1'b1;
    step();

    run_vertex({32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000},
               32'h3F80_0000, 0, "w_one_xyz");
    for (int unsigned i = 0; i < tbl.size(); i++)
      run_vertex(mk_vertex(tbl[i].w), tbl[i].req, tbl[i].tol, $sformatf("tbl%0d", i));

    // Back-to-back with valid_in held high.
    for (int unsigned i = 0; i < 3; i++) begin
      w = {1'($urandom), 8'($urandom_range(1, 252)), 23'($urandom)};
      bv[i] = mk_vertex(w);
    end
    rdy_cnt  = 0;
    valid_in = 1'b1;
    v_in     = bv[0];
    for (int unsigned c = 0; c < 3*LAT + 4; c++) begin
      bit xfer;
      if (valid_out) begin
        outc.push_back(c);
        outr.push_back(recip_out);
      end
      if (c < 3*LAT && ready_out) rdy_cnt++;
      xfer = valid_in && ready_out;
      if (xfer) acc.push_back(c);
      step();
      if (xfer) begin
        if (acc.size() < 3) v_in = bv[acc.size()];
        else valid_in = 1'b0;
      end
    end
    check_eq("b2b_accepts", 128'(acc.size()), 128'(3));
    check_eq("b2b_outputs", 128'(outc.size()), 128'(3));
    check_eq("b2b_ready_cycles", 128'(rdy_cnt), 128'(3));
    for (int unsigned i = 0; i < acc.size() && i < 3; i++)
      check_eq($sformatf("b2b_accept%0d", i), 128'(acc[i]), 128'(i*LAT));
    for (int unsigned i = 0; i < outc.size() && i < 3; i++) begin
      check_eq($sformatf("b2b_out_cycle%0d", i), 128'(outc[i]), 128'((i+1)*LAT));
      check_near($sformatf("b2b_recip%0d", i), outr[i], ref_recip(bv[i][3]), 1);
    end

    // Reset in the second MUL_B of a vertex.
    rv       = mk_vertex(32'h4120_0000);
    valid_in = 1'b1;
    v_in     = rv;
    step();
    valid_in = 1'b0;
    for (int unsigned i = 1; i < 2*ITERS; i++) step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check_eq("mid_rst_ready", 128'(ready_out), 128'(1));
    check_eq("mid_rst_valid", 128'(valid_out), 128'(0));
    check_eq("mid_rst_vout", v_out, '0);
    check_eq("mid_rst_recip", 128'(recip_out), 128'(0));
    stale = 1'b0;
    for (int unsigned i = 0; i < 3*LAT; i++) begin
      step();
      if (valid_out) stale = 1'b1;
    end
    check_eq("mid_rst_stale", 128'(stale), 128'(0));
    run_vertex(mk_vertex(32'h4120_0000), ref_recip(32'h4120_0000), 1, "after_rst");

    for (int unsigned n = 0; n < 2000; n++) begin
      w = {1'($urandom), 8'($urandom_range(1, 252)), 23'($urandom)};
      run_vertex(mk_vertex(w), ref_recip(w), 1, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
